// File: rtl/i2c_reg_sequencer.sv
// APB master that drives an I2C master peripheral through complete single-byte
// register write / read transactions, including init, status polling and recovery.
module i2c_reg_sequencer #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter logic [15:0] PRESCALE       = 16'd99,
  parameter int unsigned POLL_MAX       = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_rw_i,
  input  logic [6:0]                req_dev_i,
  input  logic [7:0]                req_reg_i,
  input  logic [7:0]                req_wdata_i,
  output logic                      resp_valid_o,
  output logic [7:0]                resp_rdata_o,
  output logic [1:0]                resp_err_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  typedef enum logic [3:0] {
    S_INIT_PRE,
    S_INIT_CTRL,
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_GAP,
    S_POLL,
    S_FETCH,
    S_ABORT,
    S_ABORT_POLL,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_NACK    = 2'b01,
    ERR_ARB     = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_e;

  localparam logic [5:0] OFF_PRE    = 6'h00;
  localparam logic [5:0] OFF_CTRL   = 6'h04;
  localparam logic [5:0] OFF_RX     = 6'h08;
  localparam logic [5:0] OFF_STATUS = 6'h0C;
  localparam logic [5:0] OFF_TX     = 6'h10;
  localparam logic [5:0] OFF_CMD    = 6'h14;

  localparam logic [7:0] CTRL_EN         = 8'h80;
  localparam logic [7:0] CMD_STA_WR      = 8'h90;
  localparam logic [7:0] CMD_WR          = 8'h10;
  localparam logic [7:0] CMD_STO_WR      = 8'h50;
  localparam logic [7:0] CMD_RD_NACK_STO = 8'h68;
  localparam logic [7:0] CMD_STO         = 8'h40;

  localparam logic [7:0] POLL_LIMIT = (POLL_MAX > 255) ? 8'hFF : 8'(POLL_MAX);

  state_e                    state_q, state_d;
  logic [1:0]                phase_q, phase_d;
  logic [7:0]                poll_cnt_q, poll_cnt_d;
  logic                      rw_q, rw_d;
  logic [6:0]                dev_q, dev_d;
  logic [7:0]                reg_q, reg_d;
  logic [7:0]                wdata_q, wdata_d;
  logic [7:0]                rdata_q, rdata_d;
  err_e                      err_q, err_d;
  logic                      resp_valid_q, resp_valid_d;
  logic                      req_ready_q, req_ready_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;

  logic [7:0]  phase_tx;
  logic [7:0]  phase_cmd;
  logic        last_phase;
  logic        read_data_phase;
  logic        acc_req;
  logic        acc_write;
  logic [5:0]  acc_off;
  logic [31:0] acc_wdata;
  logic        acc_done;
  logic [7:0]  poll_next;

  logic unused_apb;
  assign unused_apb = ^{PSLVERR, PRDATA[31:8]};

  // TX byte and command for the current phase of the latched request.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
    phase_tx  = '0;
    phase_cmd = CMD_RD_NACK_STO;
    case (phase_q)
      2'd0: begin
        phase_tx  = {dev_q, 1'b0};
        phase_cmd = CMD_STA_WR;
      end
      2'd1: begin
        phase_tx  = reg_q;
        phase_cmd = CMD_WR;
      end
      2'd2: begin
        phase_tx  = rw_q ? {dev_q, 1'b1} : wdata_q;
        phase_cmd = rw_q ? CMD_STA_WR : CMD_STO_WR;
      end
      default: begin
        phase_tx  = '0;
        phase_cmd = CMD_RD_NACK_STO;
      end
    endcase
  end

  assign read_data_phase = rw_q && (phase_q == 2'd3);
  assign last_phase      = rw_q ? (phase_q == 2'd3) : (phase_q == 2'd2);

  // Which APB access, if any, the current state performs.
  always_comb begin
    acc_req   = 1'b0;
    acc_write = 1'b0;
    acc_off   = OFF_PRE;
    acc_wdata = '0;
    case (state_q)
      S_INIT_PRE: begin
        acc_req   = 1'b1;
        acc_write = 1'b1;
        acc_off   = OFF_PRE;
        acc_wdata = {16'h0000, PRESCALE};
      end
      S_INIT_CTRL: begin
        acc_req   = 1'b1;
        acc_write = 1'b1;
        acc_off   = OFF_CTRL;
        acc_wdata = {24'h0, CTRL_EN};
      end
      S_LOAD: begin
        acc_req   = !read_data_phase;
        acc_write = 1'b1;
        acc_off   = OFF_TX;
        acc_wdata = {24'h0, phase_tx};
      end
      S_ISSUE: begin
        acc_req   = 1'b1;
        acc_write = 1'b1;
        acc_off   = OFF_CMD;
        acc_wdata = {24'h0, phase_cmd};
      end
      S_ABORT: begin
        acc_req   = 1'b1;
        acc_write = 1'b1;
        acc_off   = OFF_CMD;
        acc_wdata = {24'h0, CMD_STO};
      end
      S_POLL, S_ABORT_POLL: begin
        acc_req = 1'b1;
        acc_off = OFF_STATUS;
      end
      S_FETCH: begin
        acc_req = 1'b1;
        acc_off = OFF_RX;
      end
      default: acc_req = 1'b0;
    endcase
  end

  assign acc_done  = psel_q && penable_q && PREADY;
  assign poll_next = (poll_cnt_q == 8'hFF) ? poll_cnt_q : poll_cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    poll_cnt_d = poll_cnt_q;
    rw_d       = rw_q;
    dev_d      = dev_q;
    reg_d      = reg_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;

    // Every access starts from PSEL low, so consecutive accesses are always
    // separated by at least one idle bus cycle.
    if (acc_req) begin
      if (!psel_q) begin
        psel_d    = 1'b1;
        penable_d = 1'b0;
        pwrite_d  = acc_write;
        paddr_d   = APB_ADDR_WIDTH'(acc_off);
        pwdata_d  = acc_wdata;
      end else if (!penable_q) begin
        penable_d = 1'b1;
      end else if (PREADY) begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    end

    case (state_q)
      S_INIT_PRE:  if (acc_done) state_d = S_INIT_CTRL;
      S_INIT_CTRL: if (acc_done) state_d = S_IDLE;
      S_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          rw_d    = req_rw_i;
          dev_d   = req_dev_i;
          reg_d   = req_reg_i;
          wdata_d = req_wdata_i;
          rdata_d = '0;
          err_d   = ERR_OK;
          phase_d = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: if (!acc_req || acc_done) state_d = S_ISSUE;
      S_ISSUE: begin
        if (acc_done) begin
          poll_cnt_d = '0;
          state_d    = S_GAP;
        end
      end
      S_GAP: state_d = S_POLL;
      S_POLL: begin
        if (acc_done) begin
          poll_cnt_d = poll_next;
          if (PRDATA[5]) begin
            // The core has already released the bus after losing arbitration.
            err_d   = ERR_ARB;
            state_d = S_RESP;
          end else if (PRDATA[1]) begin
            if (poll_next >= POLL_LIMIT) begin
              err_d   = ERR_TIMEOUT;
              state_d = S_ABORT;
            end
          end else if (PRDATA[7] && !read_data_phase) begin
            err_d   = ERR_NACK;
            state_d = S_ABORT;
          end else if (last_phase) begin
            state_d = rw_q ? S_FETCH : S_RESP;
          end else begin
            phase_d = phase_q + 2'd1;
            state_d = S_LOAD;
          end
        end
      end
      S_FETCH: begin
        if (acc_done) begin
          rdata_d = PRDATA[7:0];
          state_d = S_RESP;
        end
      end
      S_ABORT: begin
        if (acc_done) begin
          poll_cnt_d = '0;
          state_d    = S_ABORT_POLL;
        end
      end
      S_ABORT_POLL: begin
        if (acc_done) begin
          poll_cnt_d = poll_next;
          if (!PRDATA[6] || (poll_next >= POLL_LIMIT)) state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_INIT_PRE;
    endcase

    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= S_INIT_PRE;
      phase_q      <= '0;
      poll_cnt_q   <= '0;
      rw_q         <= 1'b0;
      dev_q        <= '0;
      reg_q        <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= ERR_OK;
      resp_valid_q <= 1'b0;
      req_ready_q  <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      poll_cnt_q   <= poll_cnt_d;
      rw_q         <= rw_d;
      dev_q        <= dev_d;
      reg_q        <= reg_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      req_ready_q  <= req_ready_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign PSEL         = psel_q;
  assign PENABLE      = penable_q;
  assign PWRITE       = pwrite_q;
  assign PADDR        = paddr_q;
  assign PWDATA       = pwdata_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Randomized bench for i2c_reg_sequencer: a scripted I2C-peripheral APB slave plus a
// transaction-level model that predicts the APB access list and the response.
module tb_i2c_reg_sequencer;

  localparam int          AW   = 12;
  localparam int          PMAX = 4;
  localparam logic [15:0] PRE  = 16'd99;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_rw_i = 1'b0;
  logic [6:0]    req_dev_i = '0;
  logic [7:0]    req_reg_i = '0;
  logic [7:0]    req_wdata_i = '0;
  logic          resp_valid_o;
  logic [7:0]    resp_rdata_o;
  logic [1:0]    resp_err_o;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE, PSEL, PENABLE;
  logic [31:0]   PRDATA = '0;
  logic          PREADY = 1'b0;
  logic          PSLVERR = 1'b0;

  i2c_reg_sequencer #(.APB_ADDR_WIDTH(AW), .PRESCALE(PRE), .POLL_MAX(PMAX)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rw_i(req_rw_i),
    .req_dev_i(req_dev_i), .req_reg_i(req_reg_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic       rw;
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] wd;
  } req_t;

  typedef struct {
    int         tip[4];
    int         nack_phase;
    int         al_phase;
    int         to_phase;
    int         busy;
    logic [7:0] rx;
    bit         al_tip;
    bit         p3_rxack;
  } scen_t;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } acc_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  acc_t  log_q[$];
  acc_t  exp_q[$];
  scen_t sc;
  int    s_phase, s_tip_left, s_busy_left;
  bit    s_abort;
  bit    stall_once = 1'b0;
  int    stab_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Peripheral behaviour: STATUS reads walk through the scenario for the current phase.
  function automatic logic [31:0] slave_access(input acc_t a);
    logic [31:0] junk;
    logic [7:0]  st;
    junk = $urandom;
    st   = '0;
    if (a.wr) begin
      if (a.addr == 12'h014) begin
        if (a.data[7:0] == 8'h40) begin
          s_abort     = 1'b1;
          s_busy_left = sc.busy;
        end else begin
          s_phase++;
          if (s_phase == sc.to_phase) s_tip_left = 1000000;
          else if (s_phase >= 0 && s_phase < 4) s_tip_left = sc.tip[s_phase];
          else s_tip_left = 0;
        end
      end
      return 32'h0;
    end
    if (a.addr == 12'h00C) begin
      if (s_abort) begin
        st = (s_busy_left > 0) ? 8'h40 : 8'h00;
        if (s_busy_left > 0) s_busy_left--;
      end else if (s_tip_left > 0) begin
        st = 8'h42 | (($urandom_range(0, 1) == 1) ? 8'h80 : 8'h00);
        s_tip_left--;
      end else if (s_phase == sc.al_phase) begin
        st = sc.al_tip ? 8'h62 : 8'h20;
      end else if (s_phase == sc.nack_phase) begin
        st = 8'h80;
      end else if (s_phase == 3 && sc.p3_rxack) begin
        st = 8'h80;
      end
      st = st | (8'($urandom) & 8'h1D);
      return {junk[31:8], st};
    end
    if (a.addr == 12'h008) return {junk[31:8], sc.rx};
    return junk;
  endfunction

  // APB slave with random wait states; also watches signal stability during stalls.
  initial begin
    acc_t        cur;
    logic [31:0] cur_wdata;
    int          wait_left;
    cur = '0;
    cur_wdata = '0;
    wait_left = 0;
    forever begin
      @(negedge HCLK);
      if (PENABLE && !PSEL) stab_err++;
      if (PSEL && !PENABLE) begin
        cur.wr    = PWRITE;
        cur.addr  = PADDR;
        cur.data  = PWRITE ? PWDATA : 32'h0;
        cur_wdata = PWDATA;
        if (stall_once && PWRITE && PADDR == 12'h010) begin
          wait_left  = 10;
          stall_once = 1'b0;
        end else begin
          wait_left = $urandom_range(0, 2);
        end
        PREADY = 1'b0;
      end else if (PSEL && PENABLE) begin
        if (PWRITE !== cur.wr || PADDR !== cur.addr || PWDATA !== cur_wdata) stab_err++;
        if (wait_left > 0) begin
          wait_left--;
          PREADY = 1'b0;
        end else begin
          PREADY = 1'b1;
          PRDATA = slave_access(cur);
          log_q.push_back(cur);
        end
      end else begin
        PREADY = 1'b0;
      end
    end
  end

  function automatic acc_t mk(input logic wr, input logic [AW-1:0] addr, input logic [31:0] data);
    acc_t a;
    a.wr   = wr;
    a.addr = addr;
    a.data = data;
    return a;
  endfunction

  // Transaction-level prediction: ordered APB accesses plus the final response.
  task automatic model_txn(input req_t r, input scen_t s, output logic [1:0] err, output logic [7:0] rd);
    int         n;
    bit         abort;
    logic [7:0] tx, cmd;
    n = r.rw ? 4 : 3;
    abort = 1'b0;
    err = 2'b00;
    rd = 8'h00;
    exp_q.delete();
    for (int p = 0; p < n; p++) begin
      case (p)
        0:       begin tx = {r.dev, 1'b0}; cmd = 8'h90; end
        1:       begin tx = r.rg;          cmd = 8'h10; end
        2:       begin tx = r.rw ? {r.dev, 1'b1} : r.wd; cmd = r.rw ? 8'h90 : 8'h50; end
        default: begin tx = 8'h00;         cmd = 8'h68; end
      endcase
      if (p < 3) exp_q.push_back(mk(1'b1, 12'h010, {24'h0, tx}));
      exp_q.push_back(mk(1'b1, 12'h014, {24'h0, cmd}));
      if (p == s.to_phase) begin
        repeat (PMAX) exp_q.push_back(mk(1'b0, 12'h00C, 32'h0));
        err = 2'b11;
        abort = 1'b1;
        break;
      end
      repeat (s.tip[p] + 1) exp_q.push_back(mk(1'b0, 12'h00C, 32'h0));
      if (p == s.al_phase) begin
        err = 2'b10;
        break;
      end
      if (p == s.nack_phase && p < 3) begin
        err = 2'b01;
        abort = 1'b1;
        break;
      end
    end
    if (abort) begin
      exp_q.push_back(mk(1'b1, 12'h014, 32'h40));
      repeat ((s.busy + 1 < PMAX) ? s.busy + 1 : PMAX) exp_q.push_back(mk(1'b0, 12'h00C, 32'h0));
    end
    if (err == 2'b00 && r.rw) begin
      exp_q.push_back(mk(1'b0, 12'h008, 32'h0));
      rd = s.rx;
    end
  endtask

  function automatic scen_t base_scen();
    scen_t s;
    foreach (s.tip[i]) s.tip[i] = 0;
    s.nack_phase = -1;
    s.al_phase   = -1;
    s.to_phase   = -1;
    s.busy       = 0;
    s.rx         = 8'h00;
    s.al_tip     = 1'b0;
    s.p3_rxack   = 1'b0;
    return s;
  endfunction

  function automatic scen_t rand_scen(input logic rw);
    scen_t s;
    int    n;
    n = rw ? 4 : 3;
    s = base_scen();
    foreach (s.tip[i]) s.tip[i] = $urandom_range(0, PMAX - 1);
    s.busy     = $urandom_range(0, 5);
    s.rx       = 8'($urandom);
    s.al_tip   = 1'($urandom_range(0, 1));
    s.p3_rxack = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0:       s.nack_phase = $urandom_range(0, 2);
      1:       s.al_phase   = $urandom_range(0, n - 1);
      2:       s.to_phase   = $urandom_range(0, n - 1);
      default: ;
    endcase
    return s;
  endfunction

  task automatic compare_log(input string tag);
    int n;
    check({tag, "_count"}, 64'(log_q.size()), 64'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_acc"}, 64'(log_q[i]), 64'(exp_q[i]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {req_ready_o, resp_valid_o, PSEL, PENABLE, PWRITE, PADDR, PWDATA, resp_err_o, resp_rdata_o}, 64'h0);
  endtask

  task automatic expect_init();
    int cyc;
    cyc = 0;
    while (!req_ready_o && cyc < 200) begin
      @(negedge HCLK);
      cyc++;
    end
    check("init_ready", req_ready_o, 1'b1);
    exp_q.delete();
    exp_q.push_back(mk(1'b1, 12'h000, {16'h0, PRE}));
    exp_q.push_back(mk(1'b1, 12'h004, 32'h80));
    compare_log("init");
  endtask

  task automatic start_txn(input req_t r, input scen_t s);
    int cyc;
    sc          = s;
    s_phase     = -1;
    s_tip_left  = 0;
    s_busy_left = 0;
    s_abort     = 1'b0;
    log_q.delete();
    @(negedge HCLK);
    {req_rw_i, req_dev_i, req_reg_i, req_wdata_i} = r;
    req_valid_i = 1'b1;
    cyc = 0;
    while (!req_ready_o && cyc < 100) begin
      @(negedge HCLK);
      cyc++;
    end
    check("req_ready", req_ready_o, 1'b1);
    @(negedge HCLK);
    req_valid_i = 1'b0;
    {req_rw_i, req_dev_i, req_reg_i, req_wdata_i} = 24'($urandom);
    check("ready_drop", req_ready_o, 1'b0);
  endtask

  task automatic run_txn(input req_t r, input scen_t s);
    logic [1:0] e_err;
    logic [7:0] e_rd;
    int         cyc;
    model_txn(r, s, e_err, e_rd);
    start_txn(r, s);
    cyc = 0;
    while (!resp_valid_o && cyc < 2000) begin
      @(negedge HCLK);
      cyc++;
    end
    check("resp_seen", resp_valid_o, 1'b1);
    check("resp_err", resp_err_o, e_err);
    check("resp_rdata", resp_rdata_o, e_rd);
    @(negedge HCLK);
    check("resp_pulse", resp_valid_o, 1'b0);
    check("ready_idle", req_ready_o, 1'b1);
    compare_log("txn");
  endtask

  initial begin
    req_t  r;
    scen_t s;

    log_q.delete();
    repeat (3) @(negedge HCLK);
    check_reset_outputs("reset_outs");
    HRESETn = 1'b1;
    expect_init();

    // Directed write with a 10-cycle stall on the first TX write.
    r = '{rw: 1'b0, dev: 7'h50, rg: 8'h12, wd: 8'hA5};
    s = base_scen();
    stall_once = 1'b1;
    run_txn(r, s);
    check("stall_applied", stall_once, 1'b0);

    // Directed read.
    r = '{rw: 1'b1, dev: 7'h50, rg: 8'h34, wd: 8'h00};
    s = base_scen();
    s.rx = 8'h5C;
    run_txn(r, s);

    // NACK on the address byte.
    r = '{rw: 1'b0, dev: 7'h2A, rg: 8'h01, wd: 8'h77};
    s = base_scen();
    s.nack_phase = 0;
    s.busy = 2;
    run_txn(r, s);

    // Arbitration loss in P1, then a normal read.
    s = base_scen();
    s.al_phase = 1;
    run_txn(r, s);
    r = '{rw: 1'b1, dev: 7'h11, rg: 8'hF0, wd: 8'h00};
    s = base_scen();
    s.rx = 8'h3E;
    run_txn(r, s);

    // TIP stuck high in P0.
    r = '{rw: 1'b0, dev: 7'h7F, rg: 8'hFF, wd: 8'hFF};
    s = base_scen();
    s.to_phase = 0;
    run_txn(r, s);

    for (int i = 0; i < 60; i++) begin
      r.rw  = 1'($urandom_range(0, 1));
      r.dev = 7'($urandom);
      r.rg  = 8'($urandom);
      r.wd  = 8'($urandom);
      run_txn(r, rand_scen(r.rw));
    end

    // Reset in the middle of a transaction re-runs init.
    r = '{rw: 1'b1, dev: 7'h22, rg: 8'h44, wd: 8'h00};
    s = base_scen();
    s.tip[0] = 3;
    s.tip[1] = 3;
    start_txn(r, s);
    repeat ($urandom_range(3, 20)) @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    check_reset_outputs("midreset_outs");
    log_q.delete();
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    expect_init();

    check("apb_stable", 64'(stab_err), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
